// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF challenge sequencer: FSM states, default sizing
// and the width of the per-bit vote counters.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_SETTLE,
        S_SAMPLE,
        S_VOTE,
        S_OUTPUT
    } state_t;

    localparam int DEF_N_PUF         = 16;
    localparam int DEF_REPEATS       = 5;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_CHAL_W        = 8;

    // Bits needed to count 0..n inclusive.
    function automatic int vote_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Voted-response channel: valid/ready handshake carrying the challenge and its word.
// Master holds chal/word stable while valid is high and ready is low.
interface puf_challenge_sequencer_if
    import puf_ctrl_pkg::*;
#(
    parameter int N_PUF  = DEF_N_PUF,
    parameter int CHAL_W = DEF_CHAL_W
);
    logic              resp_valid;
    logic              resp_ready;
    logic [CHAL_W-1:0] resp_chal;
    logic [N_PUF-1:0]  resp_word;

    modport master (output resp_valid, output resp_chal, output resp_word, input resp_ready);
    modport slave  (input resp_valid, input resp_chal, input resp_word, output resp_ready);
endinterface

// File: rtl/puf_vote_counter.sv
// Counts the races on which one PUF bit returned 1; maj_o is the registered-count majority.
// Single-cycle clear/increment, no backpressure.
module puf_vote_counter
    import puf_ctrl_pkg::*;
#(
    parameter int REPEATS = DEF_REPEATS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic maj_o
);
    localparam int CW = vote_cnt_w(REPEATS);

    logic [CW-1:0] ones_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            ones_q <= '0;
        end else if (inc_i) begin
            ones_q <= ones_q + CW'(1);
        end
    end

    assign maj_o = (ones_q > CW'(REPEATS / 2));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sweeps challenges over a shared-bus arbiter-PUF group, races each REPEATS times and
// majority-votes every bit; first word REPEATS*(SETTLE_CYCLES+2)+2 cycles after start; stalls in OUTPUT on !ready.
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int N_PUF         = DEF_N_PUF,
    parameter int REPEATS       = DEF_REPEATS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CHAL_W        = DEF_CHAL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CHAL_W-1:0]          chal_base,
    input  logic [CHAL_W:0]            num_chal,
    output logic                       busy,
    output logic                       done,
    output logic [CHAL_W-1:0]          puf_sc,
    output logic                       puf_launch,
    input  logic [N_PUF-1:0]           puf_resp,
    puf_challenge_sequencer_if.master  resp_if
);
    localparam int RW = vote_cnt_w(REPEATS);
    localparam int SW = vote_cnt_w(SETTLE_CYCLES);
    localparam logic [CHAL_W:0] REM_ONE = (CHAL_W + 1)'(1);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               launch_q;
    logic [CHAL_W-1:0]  sc_q;
    logic [CHAL_W-1:0]  cur_chal_q;
    logic [CHAL_W-1:0]  cur_chal_d;
    logic [CHAL_W:0]    remaining_q;
    logic [RW-1:0]      rep_q;
    logic [SW-1:0]      settle_q;
    logic               valid_q;
    logic [CHAL_W-1:0]  rchal_q;
    logic [N_PUF-1:0]   rword_q;
    logic [N_PUF-1:0]   maj;

    assign cur_chal_d = cur_chal_q + CHAL_W'(1);

    for (genvar g = 0; g < N_PUF; g++) begin : g_vote
        puf_vote_counter #(
            .REPEATS (REPEATS)
        ) u_vote (
            .clk   (clk),
            .rst   (rst),
            .clr_i (state_q == S_SETUP),
            .inc_i ((state_q == S_SAMPLE) && puf_resp[g]),
            .maj_o (maj[g])
        );
    end

    // busy stays high through the done cycle, so a start coinciding with done is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            launch_q    <= 1'b0;
            sc_q        <= '0;
            cur_chal_q  <= '0;
            remaining_q <= '0;
            rep_q       <= '0;
            settle_q    <= '0;
            valid_q     <= 1'b0;
            rchal_q     <= '0;
            rword_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            launch_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start && !busy_q) begin
                        cur_chal_q  <= chal_base;
                        remaining_q <= num_chal;
                        if (num_chal == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            sc_q    <= chal_base;
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    rep_q    <= '0;
                    launch_q <= 1'b1;
                    state_q  <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    settle_q <= '0;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                S_SAMPLE: begin
                    rep_q <= rep_q + RW'(1);
                    if (rep_q == RW'(REPEATS - 1)) begin
                        state_q <= S_VOTE;
                    end else begin
                        launch_q <= 1'b1;
                        state_q  <= S_LAUNCH;
                    end
                end
                S_VOTE: begin
                    rword_q <= maj;
                    rchal_q <= cur_chal_q;
                    valid_q <= 1'b1;
                    state_q <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (resp_if.resp_ready) begin
                        valid_q     <= 1'b0;
                        remaining_q <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cur_chal_q <= cur_chal_d;
                            sc_q       <= cur_chal_d;
                            state_q    <= S_SETUP;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign puf_sc             = sc_q;
    assign puf_launch         = launch_q;
    assign resp_if.resp_valid = valid_q;
    assign resp_if.resp_chal  = rchal_q;
    assign resp_if.resp_word  = rword_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed scenarios with a response scoreboard checked by an independent monitor.
module tb_puf_challenge_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  chal_base;
    logic [8:0]  num_chal;
    logic        busy;
    logic        done;
    logic [7:0]  puf_sc;
    logic        puf_launch;
    logic [15:0] puf_resp;

    puf_challenge_sequencer_if #(.N_PUF(16), .CHAL_W(8)) rif ();

    puf_challenge_sequencer #(
        .N_PUF(16), .REPEATS(5), .SETTLE_CYCLES(4), .CHAL_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chal_base  (chal_base),
        .num_chal   (num_chal),
        .busy       (busy),
        .done       (done),
        .puf_sc     (puf_sc),
        .puf_launch (puf_launch),
        .puf_resp   (puf_resp),
        .resp_if    (rif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  chal;
        logic [15:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   launch_cnt = 0;
    int   done_cnt = 0;
    int   sc_bad = 0;
    int   stall_bad = 0;
    int   stall_launch = 0;

    logic [7:0]  sc_exp = 8'h00;
    bit          sc_chk = 1'b0;
    logic [15:0] puf_const = 16'h0000;
    bit          tbl_mode = 1'b0;
    int          tbl_idx = 0;
    logic [15:0] tbl [5] = '{16'hDA01, 16'hDA02, 16'hDA01, 16'h5A00, 16'h5A03};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // PUF group model: a new table entry is presented after each launch.
    always @(negedge clk) begin
        if (!tbl_mode) begin
            tbl_idx  = 0;
            puf_resp = puf_const;
        end else if (puf_launch) begin
            puf_resp = tbl[tbl_idx % 5];
            tbl_idx++;
        end
    end

    // Monitor: scoreboard pop on handshake, plus stall-stability and launch bookkeeping.
    logic        prev_stall = 1'b0;
    logic [7:0]  held_chal;
    logic [15:0] held_word;
    always @(negedge clk) begin
        if (!rst) begin
            if (puf_launch) begin
                launch_cnt++;
                if (sc_chk && puf_sc !== sc_exp) sc_bad++;
                if (rif.resp_valid) stall_launch++;
            end
            if (done) done_cnt++;
            if (rif.resp_valid && prev_stall &&
                (rif.resp_chal !== held_chal || rif.resp_word !== held_word)) stall_bad++;
            prev_stall = rif.resp_valid && !rif.resp_ready;
            held_chal  = rif.resp_chal;
            held_word  = rif.resp_word;
            if (rif.resp_valid && rif.resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'(rif.resp_chal), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_chal", 32'(rif.resp_chal), 32'(e.chal));
                    check("resp_word", 32'(rif.resp_word), 32'(e.word));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input logic [7:0] base, input logic [8:0] n);
        @(posedge clk); #1;
        start = 1'b1; chal_base = base; num_chal = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int k, output bit got);
        k = 0; got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (rif.resp_valid) begin got = 1'b1; break; end
        end
        if (!got) check("resp_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_single(input logic [7:0] base, input logic [15:0] expw, input string tag);
        int k; bit got; int l0; int d0; int s0;
        l0 = launch_cnt; d0 = done_cnt; s0 = sc_bad;
        sc_exp = base; sc_chk = 1'b1;
        sb_q.push_back('{chal: base, word: expw});
        do_start(base, 9'd1);
        wait_valid(100, k, got);
        check({tag, "_latency"}, 32'(k), 32'd32);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_valid_drop"}, 32'(rif.resp_valid), 32'd0);
        // start during the done cycle must be dropped
        start = 1'b1; chal_base = 8'h99; num_chal = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check({tag, "_launches"}, 32'(launch_cnt - l0), 32'd5);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_sc_at_launch"}, 32'(sc_bad - s0), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        sc_chk = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k; bit got; int l0; int d0; int sl0; int sb0;
        rst = 1'b1; start = 1'b0; chal_base = 8'h00; num_chal = 9'd0;
        rif.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_launch", 32'(puf_launch), 32'd0);
        check("rst_sc", 32'(puf_sc), 32'd0);
        check("rst_valid", 32'(rif.resp_valid), 32'd0);
        check("rst_chal", 32'(rif.resp_chal), 32'd0);
        check("rst_word", 32'(rif.resp_word), 32'd0);
        l0 = launch_cnt;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("idle_no_launch", 32'(launch_cnt - l0), 32'd0);

        puf_const = 16'hA5F0;
        run_single(8'h3C, 16'hA5F0, "single");

        tbl_mode = 1'b1;
        run_single(8'h77, 16'hDA01, "majority");
        tbl_mode = 1'b0;

        // Sweep across the 0xFF->0x00 wrap with a 10-cycle stall on each word
        puf_const = 16'h1234;
        rif.resp_ready = 1'b0;
        l0 = launch_cnt; d0 = done_cnt; sl0 = stall_launch; sb0 = stall_bad;
        sb_q.push_back('{chal: 8'hFE, word: 16'h1234});
        sb_q.push_back('{chal: 8'hFF, word: 16'h1234});
        sb_q.push_back('{chal: 8'h00, word: 16'h1234});
        do_start(8'hFE, 9'd3);
        for (int w = 0; w < 3; w++) begin
            wait_valid(200, k, got);
            if (w == 0) begin
                @(posedge clk); #1;
                start = 1'b1; chal_base = 8'h10; num_chal = 9'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
            repeat (10) @(posedge clk);
            #1 rif.resp_ready = 1'b1;
            @(posedge clk);
            #1 rif.resp_ready = 1'b0;
        end
        rif.resp_ready = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("sweep_done_count", 32'(done_cnt - d0), 32'd1);
        check("sweep_launches", 32'(launch_cnt - l0), 32'd15);
        check("sweep_no_stall_launch", 32'(stall_launch - sl0), 32'd0);
        check("sweep_stall_stable", 32'(stall_bad - sb0), 32'd0);
        check("sweep_sb_empty", 32'(sb_q.size()), 32'd0);
        check("sweep_idle", 32'(busy), 32'd0);

        // Zero-length sweep
        l0 = launch_cnt; d0 = done_cnt;
        do_start(8'h20, 9'd0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("zero_no_launch", 32'(launch_cnt - l0), 32'd0);
        check("zero_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset during the second repeat's SETTLE phase
        puf_const = 16'hA5F0;
        d0 = done_cnt;
        do_start(8'h3C, 9'd1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_launch", 32'(puf_launch), 32'd0);
        check("midrst_sc", 32'(puf_sc), 32'd0);
        check("midrst_valid", 32'(rif.resp_valid), 32'd0);
        check("midrst_word", 32'(rif.resp_word), 32'd0);
        l0 = launch_cnt;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_launch", 32'(launch_cnt - l0), 32'd0);
        run_single(8'h3C, 16'hA5F0, "after_rst");

        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Controller for a group of N_PUF arbiter-PUF instances that all share one 8-bit challenge bus and one launch/clock strobe. On request it steps through a range of challenges. Each challenge is raced REPEATS times, and each response bit is majority-voted to suppress metastable races. The voted N_PUF-bit word is returned over a valid/ready handshake. It sits between the host or UART command logic and the PUF group, and drives the group's clock and challenge inputs directly.

Parameters:
N_PUF, 16, number of PUF instances (width of response word)
REPEATS, 5, races per challenge; must be odd and >=1
SETTLE_CYCLES, 4, idle cycles after the launch edge before sampling; >=1
CHAL_W, 8, challenge width

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  request a sweep; accepted only in IDLE
chal_base  in  CHAL_W  first challenge of the sweep
num_chal  in  CHAL_W+1  number of challenges, 0..256
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the sweep completes
puf_sc  out  CHAL_W  challenge bus to the PUF group
puf_launch  out  N/A width 1  race strobe to the PUF group clock input
puf_resp  in  N_PUF  response bits from the PUF group
resp_valid  out  1  voted word available
resp_ready  in  1  consumer accepts the word
resp_chal  out  CHAL_W  challenge that produced resp_word
resp_word  out  N_PUF  majority-voted response

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous and active-high, and it overrides every other input.
- Reset state: state=IDLE; busy=0, done=0, puf_launch=0, puf_sc=0, resp_valid=0, resp_chal=0, resp_word=0; all counters are cleared.
- A reset in the middle of a sweep drops all progress, and no done pulse is issued.
- FSM states: IDLE, SETUP, LAUNCH, SETTLE, SAMPLE, VOTE, OUTPUT.
- IDLE:
  - start=1 latches chal_base into cur_chal and num_chal into remaining.
  - If num_chal=0, done pulses in the next cycle and the FSM stays in IDLE. Otherwise it goes to SETUP.
  - start is ignored whenever busy=1.
- SETUP (1 cycle): puf_sc=cur_chal, vote counters cleared, rep=0. Next state is LAUNCH.
- LAUNCH (1 cycle): puf_launch=1. This is the only state in which puf_launch is high. Next state is SETTLE.
- SETTLE: stays for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - For each bit i, ones[i] increments if puf_resp[i]=1. Counter width is clog2(REPEATS+1).
  - rep increments. If rep reaches REPEATS, next state is VOTE; otherwise it returns to LAUNCH.
- VOTE (1 cycle): resp_word[i] = (ones[i] > REPEATS/2); resp_chal = cur_chal. Next state is OUTPUT.
- OUTPUT: resp_valid=1, with resp_word and resp_chal held stable until resp_valid && resp_ready. On that handshake:
  - remaining decrements.
  - If remaining becomes 0: done pulses for 1 cycle and the FSM returns to IDLE.
  - Otherwise cur_chal increments modulo 2^CHAL_W (0xFF wraps to 0x00) and the FSM goes to SETUP.
- Back-pressure: while resp_ready is low, the FSM stays in OUTPUT and no launches occur.
- puf_sc holds its value from SETUP through OUTPUT. It changes only in SETUP, so the challenge is stable at least 1 cycle before each launch.
- Latency: resp_valid first rises in cycle REPEATS*(SETTLE_CYCLES+2)+2 after the start-accept edge. With default parameters this is cycle 32.
- Per-challenge period with resp_ready held at 1: REPEATS*(SETTLE_CYCLES+2)+3 cycles.
- done and a new start in the same cycle: the start is ignored, because busy is still 1 in that cycle.

Decomposition:
- Shared package puf_ctrl_pkg contains:
  - the FSM state enum;
  - default constants: REPEATS, SETTLE_CYCLES, CHAL_W, N_PUF;
  - a vote-counter width function.
- One sub-module, puf_vote_counter: a per-bit ones counter with clear, increment and a majority output. It is instantiated N_PUF times in a generate loop.

Test Plan:
- Reset then idle: rst for 2 cycles -> all outputs 0, busy=0; puf_launch never rises over 50 cycles.
- Single challenge, stable PUF model:
  - Stimulus: chal_base=0x3C, num_chal=1, puf_resp=0xA5F0 constant, resp_ready=1.
  - Required: exactly 5 puf_launch pulses with puf_sc=0x3C throughout; resp_valid at cycle 32 with resp_word=0xA5F0 and resp_chal=0x3C; done pulses the next cycle.
- Majority vote:
  - Stimulus: bit0 returns 1,0,1,0,1 and bit1 returns 0,1,0,0,1 across the 5 samples.
  - Required: resp_word[0]=1, resp_word[1]=0.
- Sweep with wrap and back-pressure:
  - Stimulus: chal_base=0xFE, num_chal=3, resp_ready low for 10 cycles on each word.
  - Required: resp_chal sequence 0xFE, 0xFF, 0x00; no launch while resp_valid && !resp_ready; word held stable during the stall.
- num_chal=0 and ignored start: done pulses 1 cycle after start with no launch; a start asserted mid-sweep changes neither cur_chal nor remaining.
- Reset mid-operation: assert rst during SETTLE of the 2nd repeat -> next cycle IDLE with all outputs 0 and no done pulse; a fresh start then behaves exactly as in the single-challenge scenario.
